move_mask_sequencer: RTL

MOVE_MASK_SEQUENCER -- requirements
Module: move_mask_sequencer

---
 rtl/move_mask_sequencer_pkg.sv | 39 +++
 rtl/move_mask_sequencer_dir_shifter.sv | 38 +++
 rtl/move_mask_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/move_mask_sequencer_pkg.sv
// Shared board geometry, direction and FSM encodings for the move-mask sequencer.
// Board: 32 playable squares, 8 rows of 4, square 0 top-left, row-major.
package move_mask_sequencer_pkg;

    localparam int BOARD_W = 32;

    typedef enum logic [1:0] {
        DIR_UL = 2'd0,
        DIR_UR = 2'd1,
        DIR_DL = 2'd2,
        DIR_DR = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIR_CHECK = 3'd1,
        ST_SH_OCC    = 3'd2,
        ST_SH_OPP    = 3'd3,
        ST_SH_OCC2   = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    // Diagonal neighbour of a square, or -1 when it falls off the board.
    // Even rows hold the dark squares at odd columns, odd rows at even columns.
    function automatic int neighbour(input int sq, input int dir);
        int row;
        int col;
        int nrow;
        int ncol;
        row  = sq / 4;
        col  = (row % 2 == 0) ? 2 * (sq % 4) + 1 : 2 * (sq % 4);
        nrow = (dir < 2) ? row - 1 : row + 1;
        ncol = (dir % 2 == 0) ? col - 1 : col + 1;
        if (nrow < 0 || nrow > 7 || ncol < 0 || ncol > 7)
            return -1;
        return nrow * 4 + ncol / 2;
    endfunction

endpackage

// File: rtl/move_mask_sequencer_dir_shifter.sv
// Combinational board shifters: bit i of the result is the source bit at square i's
// neighbour in the chosen direction, with 1 for neighbours that lie off the board.
module board_shift
    import move_mask_sequencer_pkg::*;
#(
    parameter int DIR = 0
) (
    input  logic [BOARD_W-1:0] x,
    output logic [BOARD_W-1:0] y
);
    for (genvar gi = 0; gi < BOARD_W; gi++) begin : g_sq
        localparam int NB = neighbour(gi, DIR);
        if (NB < 0) begin : g_edge
            assign y[gi] = 1'b1;
        end else begin : g_inner
            assign y[gi] = x[NB];
        end
    end
endmodule

module dir_shifter
    import move_mask_sequencer_pkg::*;
(
    input  logic [BOARD_W-1:0] x,
    input  dir_e               dir,
    output logic [BOARD_W-1:0] y
);
    logic [BOARD_W-1:0] shifted [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
        board_shift #(.DIR(gi)) u_shift (
            .x (x),
            .y (shifted[gi])
        );
    end

    assign y = shifted[dir];
endmodule

// File: rtl/move_mask_sequencer.sv
// Sequences the four diagonal directions through one shared shifter to build the
// per-piece simple-move and capture masks for the side to move.
module move_mask_sequencer
    import move_mask_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               side,
    input  logic [BOARD_W-1:0] own_pcs,
    input  logic [BOARD_W-1:0] opp_pcs,
    input  logic [BOARD_W-1:0] kings,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] move_mask,
    output logic [BOARD_W-1:0] jump_mask,
    output logic               must_jump
);
    state_e             state_reg, state_next;
    dir_e               dir_reg, dir_next;
    logic               side_reg, side_next;
    logic [BOARD_W-1:0] own_reg, own_next;
    logic [BOARD_W-1:0] opp_reg, opp_next;
    logic [BOARD_W-1:0] kings_reg, kings_next;
    logic [BOARD_W-1:0] s1_reg, s1_next;
    logic [BOARD_W-1:0] s2_reg, s2_next;
    logic [BOARD_W-1:0] move_reg, move_next;
    logic [BOARD_W-1:0] jump_reg, jump_next;

    logic [BOARD_W-1:0] sh_in;
    logic [BOARD_W-1:0] sh_out;
    logic [BOARD_W-1:0] movable;
    logic [1:0]         dir_inc;
    logic               forward;

    dir_shifter u_dir_shifter (
        .x   (sh_in),
        .dir (dir_reg),
        .y   (sh_out)
    );

    // Men only move toward the opponent: up for side 0, down for side 1.
    assign forward = (dir_reg[1] == side_reg);
    assign movable = (own_reg & kings_reg) | (forward ? (own_reg & ~kings_reg) : '0);
    assign dir_inc = dir_reg + 2'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_UL;
            side_reg  <= 1'b0;
            own_reg   <= '0;
            opp_reg   <= '0;
            kings_reg <= '0;
            s1_reg    <= '0;
            s2_reg    <= '0;
            move_reg  <= '0;
            jump_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            side_reg  <= side_next;
            own_reg   <= own_next;
            opp_reg   <= opp_next;
            kings_reg <= kings_next;
            s1_reg    <= s1_next;
            s2_reg    <= s2_next;
            move_reg  <= move_next;
            jump_reg  <= jump_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        side_next  = side_reg;
        own_next   = own_reg;
        opp_next   = opp_reg;
        kings_next = kings_reg;
        s1_next    = s1_reg;
        s2_next    = s2_reg;
        move_next  = move_reg;
        jump_next  = jump_reg;
        sh_in      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    side_next  = side;
                    own_next   = own_pcs;
                    opp_next   = opp_pcs;
                    kings_next = kings;
                    move_next  = '0;
                    jump_next  = '0;
                    dir_next   = DIR_UL;
                    state_next = ST_DIR_CHECK;
                end
            end
            ST_DIR_CHECK: begin
                if (movable != '0) begin
                    state_next = ST_SH_OCC;
                end else if (dir_reg == DIR_DR) begin
                    state_next = ST_DONE;
                end else begin
                    dir_next = dir_e'(dir_inc);
                end
            end
            ST_SH_OCC: begin
                sh_in      = own_reg | opp_reg;
                s1_next    = sh_out;
                state_next = ST_SH_OPP;
            end
            ST_SH_OPP: begin
                sh_in      = opp_reg;
                s2_next    = sh_out;
                state_next = ST_SH_OCC2;
            end
            ST_SH_OCC2: begin
                // sh_out here is the occupancy two squares away (the landing square).
                sh_in     = s1_reg;
                move_next = move_reg | (movable & ~s1_reg);
                jump_next = jump_reg | (movable & s2_reg & ~sh_out);
                if (dir_reg == DIR_DR) begin
                    state_next = ST_DONE;
                end else begin
                    dir_next   = dir_e'(dir_inc);
                    state_next = ST_DIR_CHECK;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign move_mask = move_reg;
    assign jump_mask = jump_reg;
    assign must_jump = |jump_reg;

endmodule
